// File: rtl/danger_scheduler.sv
// Obstacle slot scheduler for the dino game. It owns three obstacle slots and, on each
// accepted game tick, scrolls them left and retires slots that leave the screen. After a
// pseudo-random gap it spawns a new obstacle whose type comes from a Galois LFSR.
module danger_scheduler #(
    parameter logic [9:0]  SPAWN_X   = 10'd720,
    parameter logic [9:0]  FIRST_GAP = 10'd200,
    parameter logic [9:0]  MIN_GAP   = 10'd160,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       start_i,
    input  logic       game_over_i,
    input  logic [3:0] speed_i,
    input  logic       bird_allow_i,
    output logic [9:0] new_danger_pos1_o,
    output logic [9:0] new_danger_pos2_o,
    output logic [9:0] new_danger_pos3_o,
    output logic [2:0] danger_type1_o,
    output logic [2:0] danger_type2_o,
    output logic [2:0] danger_type3_o,
    output logic       danger_en1_o,
    output logic       danger_en2_o,
    output logic       danger_en3_o,
    output logic       busy_o
);

    localparam logic [2:0] TypeNothing = 3'd5;

    typedef enum logic [1:0] {StIdle, StRun, StFrozen} state_e;

    state_e          state_q;
    logic [2:0][9:0] pos_q, pos_d;
    logic [2:0][2:0] type_q, type_d;
    logic [2:0]      en_q, en_d;
    logic [9:0]      gap_q, gap_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            busy_q;

    logic [9:0]      speed_ext;
    logic [2:0]      lfsr_t;
    logic [2:0]      spawn_type;
    logic            slot_found;

    assign speed_ext = {6'd0, speed_i};

    // Map LFSR low bits onto types 0..4, substituting cacti for birds when birds are masked.
    always_comb begin
        lfsr_t = lfsr_q[2:0];
        if (lfsr_t >= 3'd5) begin
            lfsr_t = lfsr_t - 3'd5;
        end
        spawn_type = lfsr_t;
        if (!bird_allow_i) begin
            if (lfsr_t == 3'd0) begin
                spawn_type = 3'd2;
            end else if (lfsr_t == 3'd1) begin
                spawn_type = 3'd4;
            end
        end
    end

    // Next-state of slots, gap counter and LFSR for one accepted tick.
    always_comb begin
        pos_d      = pos_q;
        type_d     = type_q;
        en_d       = en_q;
        gap_d      = gap_q;
        slot_found = 1'b0;
        // Shift right, fold the dropped bit back through taps 16,14,13,11.
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        for (int i = 0; i < 3; i++) begin
            if (en_q[i]) begin
                if (pos_q[i] <= speed_ext) begin
                    en_d[i]   = 1'b0;
                    pos_d[i]  = 10'd0;
                    type_d[i] = TypeNothing;
                end else begin
                    pos_d[i] = pos_q[i] - speed_ext;
                end
            end
        end

        if (gap_q == 10'd0) begin
            // Free-slot search uses pre-tick enables so a slot retired now is not reused.
            for (int i = 0; i < 3; i++) begin
                if (!slot_found && !en_q[i]) begin
                    slot_found = 1'b1;
                    en_d[i]    = 1'b1;
                    pos_d[i]   = SPAWN_X;
                    type_d[i]  = spawn_type;
                end
            end
            if (slot_found) begin
                gap_d = MIN_GAP + {2'b00, lfsr_q[7:0]};
            end
        end else begin
            gap_d = (gap_q > speed_ext) ? gap_q - speed_ext : 10'd0;
        end
    end

    // Control FSM and all registered state; start overrides tick in every state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pos_q   <= '0;
            type_q  <= {TypeNothing, TypeNothing, TypeNothing};
            en_q    <= '0;
            gap_q   <= FIRST_GAP;
            lfsr_q  <= LFSR_SEED;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            state_q <= StRun;
            pos_q   <= '0;
            type_q  <= {TypeNothing, TypeNothing, TypeNothing};
            en_q    <= '0;
            gap_q   <= FIRST_GAP;
            lfsr_q  <= LFSR_SEED;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (game_over_i) begin
                        state_q <= StFrozen;
                        busy_q  <= 1'b0;
                    end else if (tick_i) begin
                        pos_q  <= pos_d;
                        type_q <= type_d;
                        en_q   <= en_d;
                        gap_q  <= gap_d;
                        lfsr_q <= lfsr_d;
                    end
                end
                StIdle, StFrozen: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign new_danger_pos1_o = pos_q[0];
    assign new_danger_pos2_o = pos_q[1];
    assign new_danger_pos3_o = pos_q[2];
    assign danger_type1_o    = type_q[0];
    assign danger_type2_o    = type_q[1];
    assign danger_type3_o    = type_q[2];
    assign danger_en1_o      = en_q[0];
    assign danger_en2_o      = en_q[1];
    assign danger_en3_o      = en_q[2];
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_danger_scheduler.sv
// Scoreboard bench for danger_scheduler: the driver updates a behavioural model on every
// clock and queues the expected outputs; the monitor pops and compares on the falling edge.
module tb_danger_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0, tick = 1'b0, start = 1'b0, game_over = 1'b0, bird_allow = 1'b1;
    logic [3:0] speed = 4'd0;
    logic [9:0] pos1, pos2, pos3;
    logic [2:0] typ1, typ2, typ3;
    logic       en1, en2, en3, busy;

    typedef struct packed {
        logic [2:0]  en;
        logic [29:0] pos;
        logic [8:0]  typ;
        logic        busy;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state.
    int          m_st = 0;  // 0 idle, 1 run, 2 frozen
    bit          m_en[3];
    int          m_pos[3];
    int          m_typ[3];
    int          m_gap = 200;
    logic [15:0] m_lfsr = 16'hACE1;
    int          m_spawns = 0;
    int          type_bird[8] = '{0, 1, 2, 3, 4, 0, 1, 2};
    int          type_nobird[8] = '{2, 4, 2, 3, 4, 2, 4, 2};

    // Type coverage seen on DUT outputs.
    int  phase = 0;  // 0 none, 1 birds masked, 2 birds allowed
    int  seen_masked[8];
    int  seen_allowed[8];

    always #5 clk = ~clk;

    danger_scheduler dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .tick_i            (tick),
        .start_i           (start),
        .game_over_i       (game_over),
        .speed_i           (speed),
        .bird_allow_i      (bird_allow),
        .new_danger_pos1_o (pos1),
        .new_danger_pos2_o (pos2),
        .new_danger_pos3_o (pos3),
        .danger_type1_o    (typ1),
        .danger_type2_o    (typ2),
        .danger_type3_o    (typ3),
        .danger_en1_o      (en1),
        .danger_en2_o      (en2),
        .danger_en3_o      (en3),
        .busy_o            (busy)
    );

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            m_en[i] = 0; m_pos[i] = 0; m_typ[i] = 5;
        end
        m_gap  = 200;
        m_lfsr = 16'hACE1;
    endfunction

    function automatic void model_clock();
        bit old_en[3];
        int free_slot;
        if (rst) begin
            model_clear(); m_st = 0;
        end else if (start) begin
            model_clear(); m_st = 1;
        end else if (m_st == 1 && game_over) begin
            m_st = 2;
        end else if (m_st == 1 && tick) begin
            old_en = m_en;
            for (int i = 0; i < 3; i++) begin
                if (old_en[i]) begin
                    if (m_pos[i] <= int'(speed)) begin
                        m_en[i] = 0; m_pos[i] = 0; m_typ[i] = 5;
                    end else begin
                        m_pos[i] = m_pos[i] - int'(speed);
                    end
                end
            end
            if (m_gap == 0) begin
                free_slot = -1;
                for (int i = 2; i >= 0; i--) if (!old_en[i]) free_slot = i;
                if (free_slot >= 0) begin
                    m_en[free_slot]  = 1;
                    m_pos[free_slot] = 720;
                    m_typ[free_slot] = bird_allow ? type_bird[m_lfsr[2:0]]
                                                  : type_nobird[m_lfsr[2:0]];
                    m_gap = 160 + int'(m_lfsr[7:0]);
                    m_spawns++;
                end
            end else begin
                m_gap = (m_gap > int'(speed)) ? m_gap - int'(speed) : 0;
            end
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
            else           m_lfsr = m_lfsr >> 1;
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.en   = {m_en[2], m_en[1], m_en[0]};
        o.pos  = {10'(m_pos[2]), 10'(m_pos[1]), 10'(m_pos[0])};
        o.typ  = {3'(m_typ[2]), 3'(m_typ[1]), 3'(m_typ[0])};
        o.busy = (m_st == 1);
        return o;
    endfunction

    // One clock: drive inputs, let the edge pass, update the model and queue its prediction.
    task automatic cyc(input bit r, input bit s, input bit t, input bit g, input int spd);
        rst = r; start = s; tick = t; game_over = g; speed = 4'(spd);
        @(posedge clk);
        model_clock();
        exp_q.push_back(model_obs());
        #1;
    endtask

    // Monitor: every cycle with a prediction pending, compare the full output set.
    always @(negedge clk) begin
        obs_t act, req;
        if (exp_q.size() > 0) begin
            req = exp_q.pop_front();
            act.en   = {en3, en2, en1};
            act.pos  = {pos3, pos2, pos1};
            act.typ  = {typ3, typ2, typ1};
            act.busy = busy;
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL outputs t=%0t: got en=%b pos=%0d/%0d/%0d type=%0d/%0d/%0d busy=%b, want en=%b pos=%0d/%0d/%0d type=%0d/%0d/%0d busy=%b",
                         $time, act.en, act.pos[9:0], act.pos[19:10], act.pos[29:20],
                         act.typ[2:0], act.typ[5:3], act.typ[8:6], act.busy,
                         req.en, req.pos[9:0], req.pos[19:10], req.pos[29:20],
                         req.typ[2:0], req.typ[5:3], req.typ[8:6], req.busy);
            end
            if (en1) begin
                if (phase == 1) seen_masked[typ1]++;
                if (phase == 2) seen_allowed[typ1]++;
            end
            if (en2) begin
                if (phase == 1) seen_masked[typ2]++;
                if (phase == 2) seen_allowed[typ2]++;
            end
            if (en3) begin
                if (phase == 1) seen_masked[typ3]++;
                if (phase == 2) seen_allowed[typ3]++;
            end
        end
    end

    initial begin
        int target;
        // Reset for two clocks, then ticks in IDLE must not change anything.
        cyc(1, 0, 0, 0, 4);
        cyc(1, 0, 0, 0, 4);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 4);

        // First spawn: 50 ticks drain FIRST_GAP at speed 4, the 51st spawns at 720.
        cyc(0, 1, 0, 0, 4);
        for (int i = 0; i < 52; i++) cyc(0, 0, 1, 0, 4);

        // Walk slot positions down to small values so retire boundaries get hit.
        for (int i = 0; i < 47; i++) cyc(0, 0, 1, 0, 15);
        cyc(0, 0, 1, 0, 12);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 4);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);   // stalled
        for (int i = 0; i < 40; i++) cyc(0, 0, (i % 2) == 0, 0, 7);

        // Slow scrolling fills all three slots so spawns get deferred.
        for (int i = 0; i < 1500; i++) cyc(0, 0, 1, 0, 1);
        for (int i = 0; i < 300; i++) cyc(0, 0, 1, 0, 9);

        // start and tick together: start wins.
        cyc(0, 1, 1, 0, 4);
        for (int i = 0; i < 60; i++) cyc(0, 0, 1, 0, 4);

        // Freeze with a coincident tick, ticks ignored, then restart.
        cyc(0, 0, 1, 1, 4);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, i < 3, 4);
        cyc(0, 1, 0, 0, 4);
        for (int i = 0; i < 60; i++) cyc(0, 0, 1, 0, 8);

        // Reset in the middle of a run.
        cyc(1, 0, 1, 0, 4);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 4);

        // Bird mask: many spawns with birds disallowed, then with birds allowed.
        bird_allow = 1'b0;
        cyc(0, 1, 0, 0, 15);
        phase  = 1;
        target = m_spawns + 1000;
        for (int i = 0; i < 40000 && m_spawns < target; i++) cyc(0, 0, 1, 0, 15);
        bird_allow = 1'b1;
        cyc(0, 1, 0, 0, 15);
        phase  = 2;
        target = m_spawns + 300;
        for (int i = 0; i < 15000 && m_spawns < target; i++) cyc(0, 0, 1, 0, 15);
        phase = 0;

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
        end
        checks++;
        if (m_spawns < 1300) begin
            errors++;
            $display("FAIL spawn_budget: %0d spawns, want >= 1300", m_spawns);
        end
        checks++;
        if (seen_masked[0] + seen_masked[1] != 0) begin
            errors++;
            $display("FAIL bird_masked: saw %0d bird outputs, want 0",
                     seen_masked[0] + seen_masked[1]);
        end
        checks++;
        if (seen_allowed[0] == 0 || seen_allowed[1] == 0) begin
            errors++;
            $display("FAIL bird_allowed: low=%0d high=%0d, want both nonzero",
                     seen_allowed[0], seen_allowed[1]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
